// File: rtl/stump_mem_responder.sv
// stump_mem_responder: memory-side responder for the Stump processor bus.
// Provides a word-addressed RAM and an I/O page at 0xFF00-0xFFFF with a
// buffered output FIFO, a status register, a halt register and an optional
// 32-bit cycle counter (present only when STUMP_MEM_CYCCNT_EN is defined).
module stump_mem_responder #(
   parameter int RAM_AW     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] address,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   input  logic        mem_wen,
   input  logic        mem_ren,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halted,
   output logic        bus_err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [15:0]       ram [2**RAM_AW];
   logic [15:0]       fifo [FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              overflow;

   logic              io_sel;
   logic              wr_en;
   logic              ram_we;
   logic              push;
   logic              pop;
   logic              push_ok;
   logic              drop;
   logic              status_we;
   logic              empty;
   logic              full;
   logic [RAM_AW-1:0] ram_addr;
   logic [3:0]        count4;
   logic [15:0]       status;
   logic [15:0]       cyc_lo;
   logic [15:0]       cyc_hi;

   // Decode; every write path is gated by halted so a halted system is frozen
   assign io_sel    = (address[15:8] == 8'hFF);
   assign wr_en     = mem_wen && !halted;
   assign ram_addr  = address[RAM_AW-1:0];
   assign ram_we    = wr_en && !io_sel;
   assign push      = wr_en && (address == 16'hFFF0);
   assign status_we = wr_en && (address == 16'hFFF1);

   // A push into a full FIFO still succeeds when the head leaves on the same edge
   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign tx_valid = !empty;
   assign pop      = tx_valid && tx_ready;
   assign push_ok  = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign tx_data  = tx_valid ? fifo[rd_ptr] : 16'h0000;
   assign count4   = 4'(count);
   assign status   = {8'h00, count4, 1'b0, overflow, full, empty};

   // RAM write port; contents intentionally survive reset
   always_ff @(posedge clk) begin
      if (ram_we)
         ram[ram_addr] <= wdata;
   end

   // FIFO storage; only the pointers and count need resetting
   always_ff @(posedge clk) begin
      if (push_ok)
         fifo[wr_ptr] <= wdata;
   end

   // FIFO pointers, occupancy and the sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (status_we)
            overflow <= 1'b0;
      end
   end

   // Sticky halt and bus-error flags, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted  <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         if (mem_wen && (address == 16'hFFFF))
            halted <= 1'b1;
         if (mem_wen && mem_ren)
            bus_err <= 1'b1;
      end
   end

`ifdef STUMP_MEM_CYCCNT_EN
   logic [31:0] cyc;
   logic [15:0] cyc_shadow;

   // Free-running counter that stops once halted; reading CYCLO latches the upper half
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc        <= '0;
         cyc_shadow <= '0;
      end else begin
         if (!halted)
            cyc <= cyc + 32'd1;
         if (mem_ren && (address == 16'hFFF2))
            cyc_shadow <= cyc[31:16];
      end
   end

   assign cyc_lo = cyc[15:0];
   assign cyc_hi = cyc_shadow;
`else
   assign cyc_lo = 16'h0000;
   assign cyc_hi = 16'h0000;
`endif

   // Combinational read mux; RAM reads see pre-write data during a same-cycle write
   always_comb begin
      rdata = 16'h0000;
      if (mem_ren) begin
         if (!io_sel) begin
            rdata = ram[ram_addr];
         end else begin
            case (address[7:0])
               8'hF1:   rdata = status;
               8'hF2:   rdata = cyc_lo;
               8'hF3:   rdata = cyc_hi;
               default: rdata = 16'h0000;
            endcase
         end
      end
   end

endmodule

// File: doc/stump_mem_responder.md
# stump_mem_responder

- Memory-side responder for the Stump processor bus; the counterpart to the processor's `address`/`data_out`/`data_in`/`mem_wen`/`mem_ren` interface.
- Provides a word-addressed RAM, plus a memory-mapped I/O page at 0xFF00–0xFFFF:
  - a buffered output port, drained by a valid/ready handshake;
  - a status register;
  - a 32-bit cycle counter;
  - a halt register that freezes the system.
- Replaces the behavioural bench memory in synthesizable designs.

## Interface
Parameters:
- RAM_AW, 10: RAM address width; RAM holds 2**RAM_AW 16-bit words.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, 2..8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- address  in  16  word address from Stump.
- wdata  in  16  write data; connects to Stump `data_out`.
- rdata  out  16  read data; connects to Stump `data_in`.
- mem_wen  in  1  write enable.
- mem_ren  in  1  read enable.
- tx_data  out  16  head of the output FIFO.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  consumer accepts `tx_data` when `tx_valid && tx_ready` at the rising edge.
- halted  out  1  sticky; set by a write to 0xFFFF.
- bus_err  out  1  sticky; set when `mem_wen && mem_ren` are sampled together.

## Operation
Address decode:
- `address[15:8]==8'hFF` selects I/O.
- Any other address selects RAM at `address[RAM_AW-1:0]`. Upper bits are ignored, so RAM is aliased.

RAM:
- Contents are not reset.
- A write stores `wdata` at the rising edge.
- A read returns the stored word.

I/O registers (unlisted I/O addresses read 0x0000; writes to them are ignored):
- 0xFFF0 TXDATA
  - Write: pushes `wdata` into the FIFO.
  - A push while full is dropped and sets overflow, unless a pop occurs in the same cycle; then both are performed.
  - Read: returns 0x0000.
- 0xFFF1 STATUS
  - Read fields: bit0 = empty, bit1 = full, bit2 = overflow (sticky), bits[7:4] = entry count, all other bits = 0.
  - Any write clears overflow. If a dropped push happens in the same cycle, overflow stays set.
- 0xFFF2 CYCLO: read returns `cyc[15:0]` and, on that edge, copies `cyc[31:16]` into a shadow register.
- 0xFFF3 CYCHI: read returns the shadow register, giving a coherent 32-bit sample.
- 0xFFFF HALT: any write sets `halted`.

Halt behaviour:
- Once `halted` is set, all subsequent RAM and I/O writes are suppressed.
- Reads still function.
- The FIFO continues to drain.
- Only reset clears `halted`.

Read data:
- `rdata` is combinational from `address` when `mem_ren` is high.
- `rdata` is 0x0000 when `mem_ren` is low.

Bus error:
- `mem_wen && mem_ren` sets `bus_err`.
- The write is still performed, and `rdata` returns the pre-write value.

## Timing
Reset values (asserted asynchronously when rst_n is low):
- `rdata` = 0x0000 (`mem_ren` low).
- `tx_valid` = 0, `tx_data` = 0x0000.
- `halted` = 0, `bus_err` = 0.
- FIFO empty, overflow = 0, counter = 0, shadow = 0.

Reset mid-operation flushes the FIFO contents. RAM is untouched.

Reads:
- Zero-cycle latency: `rdata` is valid in the same cycle as `address`/`mem_ren`, settling before the next rising edge.
- Read-during-write to the same RAM word returns the old data. The new data is visible from the next cycle.

FIFO:
- Push to an empty FIFO: `tx_valid` rises in the cycle after the push edge.
- The FIFO is first-word-fall-through: `tx_data` is the head entry whenever `tx_valid` is high.
- Pop happens at the edge where `tx_valid && tx_ready`.
- When `tx_valid` is 0, `tx_data` is 0x0000.

Cycle counter:
- Increments every clock after reset release.
- Wraps from 0xFFFFFFFF to 0.
- Freezes in the cycle after `halted` sets.

## Configuration
Macro `STUMP_MEM_CYCCNT_EN`:
- Defined: the cycle counter and shadow register exist as described.
- Undefined: counter and shadow are removed; 0xFFF2 and 0xFFF3 read 0x0000, and writes to them are ignored.

## Test plan
- Write 0x1234 to 0x0005, read 0x0005 next cycle -> `rdata`=0x1234. Read 0x0405 (alias, RAM_AW=10) -> 0x1234. Same-cycle read of 0x0005 during a write of 0xBEEF -> 0x1234.
- Hold `tx_ready`=0, push 0x0001..0x0005 to 0xFFF0 -> STATUS reads 0x0046 (count 4, overflow, full). Raise `tx_ready` -> `tx_data` sequence 0x0001..0x0004, then `tx_valid`=0 and STATUS=0x0005 (overflow still set). Write STATUS -> STATUS=0x0001.
- FIFO full with `tx_ready`=1, push 0xAAAA -> no overflow, count stays 4, 0xAAAA delivered last.
- Read 0xFFF2 after 100 clocks from reset release -> 0x0064 (±1 by sampling edge); 0xFFF3 -> 0x0000.
- Write 0xFFFF, then write 0x5555 to 0x0010 -> `halted`=1, 0x0010 unchanged, counter frozen. Assert `rst_n`=0 mid-cycle -> `halted`=0 and `tx_valid`=0 immediately.
- Assert `mem_wen` and `mem_ren` together at 0x0020 with old value 0x0007, `wdata`=0x0009 -> `rdata`=0x0007, `bus_err`=1, and a later read returns 0x0009.
